// File: rtl/nor_gates_bist_ctrl.sv
`default_nettype none
// ============================================================================
// nor_gates_bist_ctrl -- BIST sequencer for the 8-output NOR-built gate array
// Rev 1.0 -- initial release
// ============================================================================
module nor_gates_bist_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int LOOPS         = 1,
  parameter int ERR_CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 a_out,
  output logic                 b_out,
  input  logic [7:0]           y_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [7:0]           fail_vec,
  output logic [1:0]           first_fail_idx
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LOOP_LAST   = 8'(LOOPS - 1);

  state_t     state, state_next;
  logic [1:0] vec;
  logic [7:0] loop_cnt;
  logic [3:0] settle_cnt;
  logic [7:0] golden;
  logic [7:0] diff;
  logic       mismatch;
  logic       last_check;

  always_comb begin
    golden = 8'h00;
    case (vec)
      2'd0: golden = 8'hA7;
      2'd1: golden = 8'h69;
      2'd2: golden = 8'h6A;
      2'd3: golden = 8'h98;
      default: golden = 8'h00;
    endcase
  end

  assign diff       = y_in ^ golden;
  assign mismatch   = |diff;
  assign last_check = (vec == 2'd3) && (loop_cnt == LOOP_LAST);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_DRIVE;
      S_DRIVE:  state_next = S_SETTLE;
      S_SETTLE: if (settle_cnt == 4'd0) state_next = S_CHECK;
      S_CHECK:  state_next = last_check ? S_DONE : S_DRIVE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      vec            <= 2'd0;
      loop_cnt       <= 8'd0;
      settle_cnt     <= 4'd0;
      a_out          <= 1'b0;
      b_out          <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_vec       <= 8'h00;
      first_fail_idx <= 2'd0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            err_count      <= '0;
            fail_vec       <= 8'h00;
            first_fail_idx <= 2'd0;
            pass           <= 1'b0;
            vec            <= 2'd0;
            loop_cnt       <= 8'd0;
          end
        end
        S_DRIVE: begin
          a_out      <= vec[1];
          b_out      <= vec[0];
          settle_cnt <= SETTLE_LOAD;
        end
        S_SETTLE: begin
          if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end
        S_CHECK: begin
          if (mismatch) begin
            fail_vec <= fail_vec | diff;
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (err_count == '0) first_fail_idx <= vec;
          end
          // pass is resolved here so it is already valid while done is high
          if (last_check) begin
            pass <= !mismatch && (err_count == '0);
          end else begin
            vec <= vec + 2'd1;
            if (vec == 2'd3) loop_cnt <= loop_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nor_gates_bist_ctrl.sv
`default_nettype none
// ============================================================================
// tb_nor_gates_bist_ctrl -- scoreboard bench for the gate-array BIST sequencer
// Rev 1.0 -- initial release
// ============================================================================
module tb_nor_gates_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int         id;
    int         cyc;
    logic       pass;
    logic [3:0] err;
    logic [7:0] fv;
    logic [1:0] ffi;
  } exp_t;
  exp_t sb[$];

  function automatic logic [7:0] gate_model(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a & b), a & b, a | b, ~(a | b), ~b, ~a};
  endfunction

  // main instance: default parameters, fault-injectable gate model
  logic       start_m = 1'b0;
  logic       a_m, b_m, busy_m, done_m, pass_m;
  logic [3:0] err_m;
  logic [7:0] fv_m, y_m;
  logic [1:0] ffi_m;
  logic [7:0] and_mask = 8'hFF, or_mask = 8'h00, flip_mask = 8'h00;
  logic [1:0] flip_idx = 2'd0;
  assign y_m = ((gate_model(a_m, b_m) & and_mask) | or_mask)
             ^ (({a_m, b_m} == flip_idx) ? flip_mask : 8'h00);

  nor_gates_bist_ctrl u_main (
    .clk(clk), .rst(rst), .start(start_m), .a_out(a_m), .b_out(b_m), .y_in(y_m),
    .busy(busy_m), .done(done_m), .pass(pass_m), .err_count(err_m),
    .fail_vec(fv_m), .first_fail_idx(ffi_m)
  );

  // saturation instance: LOOPS=8, outputs tied low
  logic       start_x = 1'b0;
  logic       a_sat, b_sat, busy_sat, done_sat, pass_sat;
  logic [3:0] err_sat;
  logic [7:0] fv_sat;
  logic [1:0] ffi_sat;

  nor_gates_bist_ctrl #(.LOOPS(8)) u_sat (
    .clk(clk), .rst(rst), .start(start_x), .a_out(a_sat), .b_out(b_sat), .y_in(8'h00),
    .busy(busy_sat), .done(done_sat), .pass(pass_sat), .err_count(err_sat),
    .fail_vec(fv_sat), .first_fail_idx(ffi_sat)
  );

  // settle instances: SETTLE_CYCLES=3 against 3- and 4-cycle delayed gates
  logic       a_s3, b_s3, busy_s3, done_s3, pass_s3;
  logic       a_s4, b_s4, busy_s4, done_s4, pass_s4;
  logic [3:0] err_s3, err_s4;
  logic [7:0] fv_s3, fv_s4;
  logic [1:0] ffi_s3, ffi_s4;
  logic [7:0] dl3 [3];
  logic [7:0] dl4 [4];

  always @(posedge clk) begin
    dl3[0] <= gate_model(a_s3, b_s3);
    dl3[1] <= dl3[0];
    dl3[2] <= dl3[1];
    dl4[0] <= gate_model(a_s4, b_s4);
    dl4[1] <= dl4[0];
    dl4[2] <= dl4[1];
    dl4[3] <= dl4[2];
  end

  nor_gates_bist_ctrl #(.SETTLE_CYCLES(3)) u_s3 (
    .clk(clk), .rst(rst), .start(start_x), .a_out(a_s3), .b_out(b_s3), .y_in(dl3[2]),
    .busy(busy_s3), .done(done_s3), .pass(pass_s3), .err_count(err_s3),
    .fail_vec(fv_s3), .first_fail_idx(ffi_s3)
  );

  nor_gates_bist_ctrl #(.SETTLE_CYCLES(3)) u_s4 (
    .clk(clk), .rst(rst), .start(start_x), .a_out(a_s4), .b_out(b_s4), .y_in(dl4[3]),
    .busy(busy_s4), .done(done_s4), .pass(pass_s4), .err_count(err_s4),
    .fail_vec(fv_s4), .first_fail_idx(ffi_s4)
  );

  logic [3:0] done_v, pass_v;
  logic [3:0] err_v [4];
  logic [7:0] fv_v  [4];
  logic [1:0] ffi_v [4];
  assign done_v = {done_s4, done_s3, done_sat, done_m};
  assign pass_v = {pass_s4, pass_s3, pass_sat, pass_m};
  assign err_v[0] = err_m;   assign err_v[1] = err_sat;
  assign err_v[2] = err_s3;  assign err_v[3] = err_s4;
  assign fv_v[0]  = fv_m;    assign fv_v[1]  = fv_sat;
  assign fv_v[2]  = fv_s3;   assign fv_v[3]  = fv_s4;
  assign ffi_v[0] = ffi_m;   assign ffi_v[1] = ffi_sat;
  assign ffi_v[2] = ffi_s3;  assign ffi_v[3] = ffi_s4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input int id, input int cyc, input logic p, input logic [3:0] e,
                      input logic [7:0] fv, input logic [1:0] ffi);
    exp_t x;
    x.id = id; x.cyc = cyc; x.pass = p; x.err = e; x.fv = fv; x.ffi = ffi;
    sb.push_back(x);
  endtask

  // monitor: every done pulse consumes the oldest expectation for that instance
  int mon_found;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done_v[i]) begin
        mon_found = -1;
        for (int j = 0; j < sb.size(); j++)
          if (mon_found < 0 && sb[j].id == i) mon_found = j;
        if (mon_found < 0) begin
          chk($sformatf("unexpected_done[%0d]", i), 32'd1, 32'd0);
        end else begin
          chk($sformatf("done_cycle[%0d]", i), edges, sb[mon_found].cyc);
          chk($sformatf("pass[%0d]", i), 32'(pass_v[i]), 32'(sb[mon_found].pass));
          chk($sformatf("err_count[%0d]", i), 32'(err_v[i]), 32'(sb[mon_found].err));
          chk($sformatf("fail_vec[%0d]", i), 32'(fv_v[i]), 32'(sb[mon_found].fv));
          chk($sformatf("first_fail_idx[%0d]", i), 32'(ffi_v[i]), 32'(sb[mon_found].ffi));
          sb.delete(mon_found);
        end
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({name, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic set_model(input logic [7:0] am, input logic [7:0] om,
                           input logic [7:0] fm, input logic [1:0] fi);
    and_mask = am; or_mask = om; flip_mask = fm; flip_idx = fi;
  endtask

  task automatic single_run(input string name, input logic p, input logic [3:0] e,
                            input logic [7:0] fv, input logic [1:0] ffi);
    @(negedge clk);
    push(0, edges + 13, p, e, fv, ffi);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    drain(name);
  endtask

  initial begin
    int s;
    for (int i = 0; i < 3; i++) dl3[i] = 8'h00;
    for (int i = 0; i < 4; i++) dl4[i] = 8'h00;
    rst = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy_m), 0);
    chk("reset_done", 32'(done_m), 0);
    chk("reset_pass", 32'(pass_m), 0);
    chk("reset_err", 32'(err_m), 0);
    chk("reset_fail_vec", 32'(fv_m), 0);
    chk("reset_ffi", 32'(ffi_m), 0);
    chk("reset_ab", 32'({a_m, b_m}), 0);

    // correct model on main, plus saturation and settle instances together
    s = edges;
    push(0, s + 13, 1'b1, 4'd0,  8'h00, 2'd0);
    push(1, s + 97, 1'b0, 4'd15, 8'hFF, 2'd0);
    push(2, s + 21, 1'b1, 4'd0,  8'h00, 2'd0);
    push(3, s + 21, 1'b0, 4'd3,  8'hFF, 2'd1);
    start_m = 1'b1;
    start_x = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    start_x = 1'b0;
    drain("run_good");

    set_model(8'hBF, 8'h00, 8'h00, 2'd0);
    single_run("run_y6_sa0", 1'b0, 4'd2, 8'h40, 2'd1);
    set_model(8'hFF, 8'h00, 8'h04, 2'd2);
    single_run("run_flip_v2", 1'b0, 4'd1, 8'h04, 2'd2);
    set_model(8'hFF, 8'h10, 8'h00, 2'd0);
    single_run("run_y4_sa1", 1'b0, 4'd3, 8'h10, 2'd0);

    // start re-pulsed during the run must be ignored
    set_model(8'hFF, 8'h00, 8'h00, 2'd0);
    @(negedge clk);
    s = edges;
    push(0, s + 13, 1'b1, 4'd0, 8'h00, 2'd0);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    repeat (2) @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    repeat (3) @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    drain("run_repulse");

    // start held high: a second run follows straight from IDLE
    @(negedge clk);
    s = edges;
    push(0, s + 13, 1'b1, 4'd0, 8'h00, 2'd0);
    push(0, s + 27, 1'b1, 4'd0, 8'h00, 2'd0);
    start_m = 1'b1;
    repeat (16) @(negedge clk);
    start_m = 1'b0;
    drain("run_held");

    // reset mid-run after the first failing check
    set_model(8'hBF, 8'h00, 8'h00, 2'd0);
    @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrun_err", 32'(err_m), 1);
    chk("midrun_busy", 32'(busy_m), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("after_rst_busy", 32'(busy_m), 0);
    chk("after_rst_done", 32'(done_m), 0);
    chk("after_rst_err", 32'(err_m), 0);
    chk("after_rst_fail_vec", 32'(fv_m), 0);
    repeat (5) @(negedge clk);
    set_model(8'hFF, 8'h00, 8'h00, 2'd0);
    single_run("run_after_rst", 1'b1, 4'd0, 8'h00, 2'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
